// File: rtl/ahb_apb_multi_bridge.sv
// rtl/ahb_apb_multi_bridge.sv - AHB to multi-slave APB bridge with error and timeout handling
module ahb_apb_multi_bridge #(
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int NUM_SLAVES      = 4,
    parameter int SLAVE_ADDR_BITS = 12,
    parameter int TIMEOUT_CYCLES  = 256
) (
    input  logic                             HCLK,
    input  logic                             HRESETn,
    input  logic                             HSEL,
    input  logic [ADDR_WIDTH-1:0]            HADDR,
    input  logic [1:0]                       HTRANS,
    input  logic                             HWRITE,
    input  logic                             HREADY,
    input  logic [DATA_WIDTH-1:0]            HWDATA,
    output logic [DATA_WIDTH-1:0]            HRDATA,
    output logic [1:0]                       HRESP,
    output logic                             HREADYOUT,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);
    localparam int IDXW = ADDR_WIDTH - SLAVE_ADDR_BITS;
    localparam int IW   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_WLATCH = 3'd1;
    localparam logic [2:0] ST_SETUP  = 3'd2;
    localparam logic [2:0] ST_ACCESS = 3'd3;
    localparam logic [2:0] ST_ERR1   = 3'd4;
    localparam logic [2:0] ST_ERR2   = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  write_q, write_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic [IDXW-1:0]       raw_idx;
    logic                  accept;
    logic                  take;
    logic                  sel_ready;
    logic                  sel_err;
    logic [DATA_WIDTH-1:0] sel_rdata;
    logic                  done;
    logic [CW-1:0]         cnt_inc;

    always_comb begin
        raw_idx   = HADDR[ADDR_WIDTH-1:SLAVE_ADDR_BITS];
        accept    = HSEL & HREADY & ((HTRANS == 2'b10) | (HTRANS == 2'b11));
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IW'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        done    = (state_q == ST_ACCESS) & sel_ready & ~sel_err;
        cnt_inc = cnt_q + CW'(1);
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        idx_d    = idx_q;
        pwdata_d = pwdata_q;
        cnt_d    = cnt_q;
        take     = 1'b0;
        case (state_q)
            ST_IDLE:   take = accept;
            ST_WLATCH: begin
                // AHB write data arrives one cycle after the address phase
                pwdata_d = HWDATA;
                state_d  = ST_SETUP;
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (sel_ready) begin
                    if (sel_err) begin
                        state_d = ST_ERR1;
                    end else begin
                        state_d = ST_IDLE;
                        take    = accept;
                    end
                end else begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_inc;
                    end
                    if ((TIMEOUT_CYCLES > 0) && (cnt_inc == TO_VAL)) begin
                        state_d = ST_ERR1;
                    end
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2: begin
                state_d = ST_IDLE;
                take    = accept;
            end
            default:   state_d = ST_IDLE;
        endcase
        if (take) begin
            addr_d  = HADDR;
            write_d = HWRITE;
            idx_d   = raw_idx[IW-1:0];
            if (raw_idx >= IDXW'(NUM_SLAVES)) begin
                state_d = ST_ERR1;
            end else if (HWRITE) begin
                state_d = ST_WLATCH;
            end else begin
                state_d = ST_SETUP;
            end
        end
        if (state_d == ST_SETUP) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            pwdata_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            pwdata_q <= pwdata_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            PSEL[i] = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && (idx_q == IW'(i));
        end
        PENABLE = (state_q == ST_ACCESS);
        PADDR   = addr_q;
        PWRITE  = write_q;
        PWDATA  = pwdata_q;
        case (state_q)
            ST_IDLE, ST_ERR2: HREADYOUT = 1'b1;
            ST_ACCESS:        HREADYOUT = done;
            default:          HREADYOUT = 1'b0;
        endcase
        HRESP  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
        HRDATA = (done && !write_q) ? sel_rdata : '0;
    end
endmodule

// File: doc/ahb_apb_multi_bridge.md
AHB_APB_MULTI_BRIDGE -- requirements
Module: ahb_apb_multi_bridge

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_WIDTH, 32, AHB/APB address width.
- DATA_WIDTH, 32, data width.
- NUM_SLAVES, 4, APB slave count; legal range 1..16.
- SLAVE_ADDR_BITS, 12, per-slave window size is 2^SLAVE_ADDR_BITS bytes.
- TIMEOUT_CYCLES, 256, maximum ACCESS wait cycles; 0 disables the timeout.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- HCLK, in, 1, sole clock, rising edge.
- HRESETn, in, 1, reset; synchronous, active-low.
- HSEL, in, 1, bridge select.
- HADDR, in, ADDR_WIDTH, address.
- HTRANS, in, 2, transfer type.
- HWRITE, in, 1, 1=write.
- HREADY, in, 1, bus ready.
- HWDATA, in, DATA_WIDTH, write data.
- HRDATA, out, DATA_WIDTH, read data.
- HRESP, out, 2, 00=OKAY, 01=ERROR.
- HREADYOUT, out, 1, bridge ready.
- PSEL, out, NUM_SLAVES, one-hot slave select.
- PENABLE, out, 1, access phase.
- PADDR, out, ADDR_WIDTH, APB address.
- PWRITE, out, 1, APB direction.
- PWDATA, out, DATA_WIDTH, APB write data.
- PRDATA, in, NUM_SLAVES*DATA_WIDTH, read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- PREADY, in, NUM_SLAVES, per-slave ready.
- PSLVERR, in, NUM_SLAVES, per-slave error.

Function
REQ-003 Accept SHALL be HSEL & HTRANS[1] & HREADY, sampled only in IDLE, in ACCESS on the completing cycle, and in ERR2; IDLE/BUSY transfers SHALL be ignored with OKAY.
REQ-004 On accept, the bridge SHALL register HADDR, HWRITE and slave index idx = HADDR[ADDR_WIDTH-1:SLAVE_ADDR_BITS].
REQ-005 The FSM SHALL have the states IDLE, WLATCH, SETUP, ACCESS, ERR1 and ERR2.
REQ-006 The accepted transfer SHALL route as follows: idx >= NUM_SLAVES -> ERR1 with no APB activity; write -> WLATCH; read -> SETUP.
REQ-007 WLATCH SHALL last 1 cycle, capture HWDATA into PWDATA, hold HREADYOUT=0, and go to SETUP.
REQ-008 SETUP SHALL last 1 cycle with PSEL[idx]=1, PENABLE=0, PADDR/PWRITE from the registers and HREADYOUT=0, then go to ACCESS.
REQ-009 ACCESS SHALL drive PSEL[idx]=1 and PENABLE=1, and SHALL hold PADDR, PWRITE and PWDATA stable until exit.
REQ-010 In ACCESS with PREADY[idx]=0, HREADYOUT SHALL be 0 and the wait counter SHALL increment.
REQ-011 In ACCESS with PREADY[idx]=1 and PSLVERR[idx]=0, the bridge SHALL drive HREADYOUT=1 and HRESP=OKAY in the same cycle; reads SHALL drive HRDATA = PRDATA slice idx combinationally. The next state SHALL be SETUP/WLATCH on a new accept, else IDLE.
REQ-012 In ACCESS with PREADY[idx]=1 and PSLVERR[idx]=1, the next state SHALL be ERR1.
REQ-013 When TIMEOUT_CYCLES>0 and the wait counter reaches TIMEOUT_CYCLES with PREADY[idx] still 0, the bridge SHALL go to ERR1, deasserting PSEL and PENABLE next cycle.
REQ-014 The wait counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide, clear on entry to SETUP, and never wrap.
REQ-015 ERR1 SHALL drive HRESP=ERROR and HREADYOUT=0 for 1 cycle.
REQ-016 ERR2 SHALL drive HRESP=ERROR and HREADYOUT=1 for 1 cycle, then go to SETUP/WLATCH on accept, else IDLE.
REQ-017 PSEL SHALL be all-zero in IDLE, WLATCH, ERR1 and ERR2, and at most one PSEL bit SHALL ever be high.
REQ-018 HRDATA SHALL be 0 except on a completing read cycle.
REQ-019 In IDLE the bridge SHALL drive HREADYOUT=1 and HRESP=OKAY.
REQ-020 Minimum latency, accept to HREADYOUT=1, SHALL be 2 cycles for a read and 3 for a write.

Reset
REQ-021 While HRESETn=0 at a rising HCLK edge, the bridge SHALL enter IDLE with PSEL=0, PENABLE=0, PADDR=0, PWRITE=0, PWDATA=0, HRDATA=0, HRESP=OKAY, HREADYOUT=1, wait counter=0 and address/index registers=0.
REQ-022 Reset asserted mid-transfer (any state) SHALL abort the transfer with no further APB access and no error response.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- Read at 0x0000_1004 with PREADY[1]=1, PRDATA slice1=0xCAFE_0001 -> PSEL=0010, PADDR=0x1004, HREADYOUT=1 with HRDATA=0xCAFE_0001 two cycles after accept, HRESP=OKAY.
- Write 0xDEAD_BEEF to 0x0000_2008 -> WLATCH, then PSEL=0100 with PWDATA=0xDEAD_BEEF, PWRITE=1 through SETUP+ACCESS; completes 3 cycles after accept.
- Read to slave 3 with PREADY[3] low 5 cycles -> HREADYOUT low 6 cycles (SETUP+5), PADDR stable; completes on the 6th ACCESS cycle.
- Write with PREADY[0]=1, PSLVERR[0]=1 -> ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01), then IDLE.
- Address 0x0000_5000 with NUM_SLAVES=4 -> PSEL stays 0000, two-cycle ERROR; TIMEOUT_CYCLES=4 with PREADY stuck low -> PSEL drops after 4 wait cycles, two-cycle ERROR.
- Back-to-back: read then write accepted on the completing cycle -> no IDLE gap; HRESETn=0 during ACCESS -> PSEL=0, HREADYOUT=1 on the next edge.
